// File: rtl/captura_pkg.sv
// Shared definitions for the request-capture block.
// Contents:
//   - field widths for user, function and step-counter codes
//   - BTN bit roles (commit/step per port)
//   - per-port state enum (idle / hold)
//   - snapshot helpers that build USER/FUNC from the switch bits
package captura_pkg;

    localparam int unsigned USER_W    = 3;
    localparam int unsigned FUNC_W    = 3;
    localparam int unsigned SEL_W     = 2;
    localparam int unsigned TIMER_W   = 8;
    localparam int unsigned DEB_CNT_W = 8;
    localparam int unsigned NUM_PORTS = 2;
    localparam int unsigned NUM_BTN   = 4;

    // BTN bit roles
    localparam int unsigned BTN_COMMIT0 = 0;
    localparam int unsigned BTN_STEP0   = 1;
    localparam int unsigned BTN_STEP1   = 2;
    localparam int unsigned BTN_COMMIT1 = 3;

    typedef enum logic {
        StIdle = 1'b0,
        StHold = 1'b1
    } port_state_e;

    // Switches are wired LSB-first to the user code: sw[0] becomes the MSB.
    function automatic logic [USER_W-1:0] user_snapshot(input logic [2:0] sw);
        return {sw[0], sw[1], sw[2]};
    endfunction

    function automatic logic [FUNC_W-1:0] func_snapshot(input logic msb,
                                                        input logic [SEL_W-1:0] sel);
        return {msb, sel};
    endfunction

endpackage

// File: rtl/debounce_botao.sv
// Two-flop synchroniser plus debouncer for one raw push button.
// The debounced level flips only after DEBOUNCE_CYCLES consecutive synchronised
// samples at the new level; any sample back at the old level restarts the count.
// A rising edge of the debounced level yields one registered 1-cycle pulse.
// Ports:
//   clk_i   - clock, rising edge
//   rst_ni  - asynchronous active-low reset
//   btn_i   - raw button, asynchronous to clk_i
//   pulse_o - 1-cycle pulse per accepted press
module debounce_botao
    import captura_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic pulse_o
);

    localparam logic [DEB_CNT_W-1:0] CntLast = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                 sync1_q, sync2_q;
    logic                 level_q, level_d;
    logic                 level_prev_q;
    logic                 pulse_q;
    logic [DEB_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + DEB_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            pulse_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn_i;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            pulse_q      <= level_q & ~level_prev_q;
            cnt_q        <= cnt_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/captura_requisicao.sv
// Request capture stage: turns raw switches and buttons into latched
// (user, function) requests for two independent ports.
// Each port has a function-step counter (stepped by its step button) and an
// idle/hold FSM; a commit press snapshots the switches plus the step counter
// and keeps VALIDn high for HOLD_CYCLES cycles (a new commit reloads the timer).
// Optional feature, macro CAPTURA_LOCK_EN: a commit whose function equals the
// function held by the other port is rejected and pulses err_o; simultaneous
// commits with equal function keep the higher user code (tie: port 0).
// Without the macro every commit is accepted and err_o is 0.
// Ports:
//   clk_i, rst_ni         - clock; asynchronous active-low reset
//   ch_i[7:0]             - raw switches (synchronised, not debounced)
//   btn_i[3:0]            - raw buttons: 0 commit p0, 1 step p0, 2 step p1, 3 commit p1
//   user0_o/user1_o       - latched user codes
//   func0_o/func1_o       - latched function codes
//   valid0_o/valid1_o     - latched request live
//   sel0_o/sel1_o         - current function-step counters
//   err_o                 - 1-cycle pulse on a rejected commit
module captura_requisicao
    import captura_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES     = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [7:0]        ch_i,
    input  logic [3:0]        btn_i,
    output logic [USER_W-1:0] user0_o,
    output logic [USER_W-1:0] user1_o,
    output logic [FUNC_W-1:0] func0_o,
    output logic [FUNC_W-1:0] func1_o,
    output logic              valid0_o,
    output logic              valid1_o,
    output logic [SEL_W-1:0]  sel0_o,
    output logic [SEL_W-1:0]  sel1_o,
    output logic              err_o
);

    localparam logic [TIMER_W-1:0] HoldLoad = TIMER_W'(HOLD_CYCLES);

    logic [NUM_BTN-1:0]   btn_pulse;
    logic [NUM_PORTS-1:0] commit_pulse, step_pulse, accept;
    logic [7:0]           ch_s1_q, ch_s2_q;

    port_state_e          state_q [NUM_PORTS];
    port_state_e          state_d [NUM_PORTS];
    logic [TIMER_W-1:0]   timer_q [NUM_PORTS];
    logic [TIMER_W-1:0]   timer_d [NUM_PORTS];
    logic [USER_W-1:0]    user_q  [NUM_PORTS];
    logic [USER_W-1:0]    user_d  [NUM_PORTS];
    logic [FUNC_W-1:0]    func_q  [NUM_PORTS];
    logic [FUNC_W-1:0]    func_d  [NUM_PORTS];
    logic [SEL_W-1:0]     sel_q   [NUM_PORTS];
    logic [SEL_W-1:0]     sel_d   [NUM_PORTS];
    logic [USER_W-1:0]    snap_user [NUM_PORTS];
    logic [FUNC_W-1:0]    snap_func [NUM_PORTS];

    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        debounce_botao #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .btn_i  (btn_i[b]),
            .pulse_o(btn_pulse[b])
        );
    end

    assign commit_pulse = {btn_pulse[BTN_COMMIT1], btn_pulse[BTN_COMMIT0]};
    assign step_pulse   = {btn_pulse[BTN_STEP1], btn_pulse[BTN_STEP0]};

    // Snapshots use the pre-increment step counter when a step lands in the same cycle.
    assign snap_user[0] = user_snapshot(ch_s2_q[2:0]);
    assign snap_user[1] = user_snapshot(ch_s2_q[6:4]);
    assign snap_func[0] = func_snapshot(ch_s2_q[3], sel_q[0]);
    assign snap_func[1] = func_snapshot(ch_s2_q[7], sel_q[1]);

`ifdef CAPTURA_LOCK_EN
    logic [NUM_PORTS-1:0] reject;
    logic                 err_q;

    always_comb begin
        reject = '0;
        if (commit_pulse[0] && commit_pulse[1]) begin
            // Both snapshots replace whatever was held, so they only contend with each other.
            if (snap_func[0] == snap_func[1]) begin
                if (snap_user[1] > snap_user[0]) begin
                    reject[0] = 1'b1;
                end else begin
                    reject[1] = 1'b1;
                end
            end
        end else begin
            if (commit_pulse[0] && (state_q[1] == StHold) && (snap_func[0] == func_q[1])) begin
                reject[0] = 1'b1;
            end
            if (commit_pulse[1] && (state_q[0] == StHold) && (snap_func[1] == func_q[0])) begin
                reject[1] = 1'b1;
            end
        end
        accept = commit_pulse & ~reject;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= |reject;
        end
    end

    assign err_o = err_q;
`else
    always_comb begin
        accept = commit_pulse;
    end

    assign err_o = 1'b0;
`endif

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            state_d[p] = state_q[p];
            timer_d[p] = timer_q[p];
            user_d[p]  = user_q[p];
            func_d[p]  = func_q[p];
            sel_d[p]   = step_pulse[p] ? sel_q[p] + SEL_W'(1) : sel_q[p];
            unique case (state_q[p])
                StIdle: begin
                    if (accept[p]) begin
                        state_d[p] = StHold;
                        timer_d[p] = HoldLoad;
                        user_d[p]  = snap_user[p];
                        func_d[p]  = snap_func[p];
                    end
                end
                StHold: begin
                    if (accept[p]) begin
                        timer_d[p] = HoldLoad;
                        user_d[p]  = snap_user[p];
                        func_d[p]  = snap_func[p];
                    end else if (timer_q[p] == TIMER_W'(1)) begin
                        state_d[p] = StIdle;
                        timer_d[p] = '0;
                    end else begin
                        timer_d[p] = timer_q[p] - TIMER_W'(1);
                    end
                end
                default: begin
                    state_d[p] = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ch_s1_q <= '0;
            ch_s2_q <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                state_q[p] <= StIdle;
                timer_q[p] <= '0;
                user_q[p]  <= '0;
                func_q[p]  <= '0;
                sel_q[p]   <= '0;
            end
        end else begin
            ch_s1_q <= ch_i;
            ch_s2_q <= ch_s1_q;
            for (int p = 0; p < NUM_PORTS; p++) begin
                state_q[p] <= state_d[p];
                timer_q[p] <= timer_d[p];
                user_q[p]  <= user_d[p];
                func_q[p]  <= func_d[p];
                sel_q[p]   <= sel_d[p];
            end
        end
    end

    assign user0_o  = user_q[0];
    assign user1_o  = user_q[1];
    assign func0_o  = func_q[0];
    assign func1_o  = func_q[1];
    assign sel0_o   = sel_q[0];
    assign sel1_o   = sel_q[1];
    assign valid0_o = (state_q[0] == StHold);
    assign valid1_o = (state_q[1] == StHold);

endmodule

// File: tb/tb_captura_requisicao.sv
`timescale 1ns/1ps
module tb_captura_requisicao;

    localparam int DEB    = 4;
    localparam int HOLD   = 8;
    localparam int MAXLEN = 256;
    localparam int TAIL   = 12;
    localparam int ROUNDS = 40;
    // Raw level driven after edge n is first sampled at edge n+1; outputs react 7 edges later.
    localparam int LAT    = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ch;
    logic [3:0] btn;
    logic [2:0] user0, user1, func0, func1;
    logic       valid0, valid1, err;
    logic [1:0] sel0, sel1;

    captura_requisicao #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .ch_i    (ch),
        .btn_i   (btn),
        .user0_o (user0),
        .user1_o (user1),
        .func0_o (func0),
        .func1_o (func1),
        .valid0_o(valid0),
        .valid1_o(valid1),
        .sel0_o  (sel0),
        .sel1_o  (sel1),
        .err_o   (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        int cyc;
        int v0, v1, u0, u1, f0, f1, s0, s1, er;
    } exp_t;

    exp_t sb_q[$];

    // Monitor: compares every cycle the scoreboard has an expectation for.
    always @(negedge clk) begin
        exp_t rec;
        if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
            rec = sb_q.pop_front();
            chk("valid0", 8'(valid0), 8'(rec.v0));
            chk("valid1", 8'(valid1), 8'(rec.v1));
            chk("user0",  8'(user0),  8'(rec.u0));
            chk("user1",  8'(user1),  8'(rec.u1));
            chk("func0",  8'(func0),  8'(rec.f0));
            chk("func1",  8'(func1),  8'(rec.f1));
            chk("sel0",   8'(sel0),   8'(rec.s0));
            chk("sel1",   8'(sel1),   8'(rec.s1));
            chk("err",    8'(err),    8'(rec.er));
        end
    end

    // Stimulus for one round: raw levels per cycle and the cycles at which a press counts.
    logic [3:0] pat [MAXLEN];
    logic [3:0] ev  [MAXLEN];

    // Reference model state: a request stays valid up to and including cycle m_vend.
    int m_vend [2];
    int m_user [2];
    int m_func [2];
    int m_sel  [2];

    // Low gaps of at least DEB cycles separate events; bounces are runs shorter than DEB;
    // a press is a high run of at least DEB cycles and counts once, LAT cycles after it starts.
    task automatic gen_button(input int b, input int body, output int endp);
        int pos = 0;
        int n;
        while (pos < body) begin
            pos += DEB + $urandom_range(0, 5);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    n = $urandom_range(1, DEB - 1);
                    for (int i = 0; i < n; i++) pat[pos + i][b] = 1'b1;
                    pos += n;
                    pos += $urandom_range(1, DEB - 1);
                end
            end
            if ($urandom_range(0, 1) == 1) begin
                ev[pos + LAT][b] = 1'b1;
                n = DEB + $urandom_range(0, 5);
                for (int i = 0; i < n; i++) pat[pos + i][b] = 1'b1;
                pos += n;
            end
        end
        endp = pos;
    endtask

    task automatic model_cycle(input int c, input logic [3:0] evb, input logic [7:0] chv,
                               output exp_t rec);
        int su [2];
        int sf [2];
        bit com [2];
        bit rej [2];
        bit hold_prev [2];
        com[0] = evb[0];
        com[1] = evb[3];
        su[0] = int'(chv[0]) * 4 + int'(chv[1]) * 2 + int'(chv[2]);
        su[1] = int'(chv[4]) * 4 + int'(chv[5]) * 2 + int'(chv[6]);
        sf[0] = int'(chv[3]) * 4 + m_sel[0];
        sf[1] = int'(chv[7]) * 4 + m_sel[1];
        for (int p = 0; p < 2; p++) begin
            hold_prev[p] = (c - 1 <= m_vend[p]);
            rej[p] = 1'b0;
        end
`ifdef CAPTURA_LOCK_EN
        if (com[0] && com[1]) begin
            if (sf[0] == sf[1]) begin
                if (su[1] > su[0]) rej[0] = 1'b1;
                else rej[1] = 1'b1;
            end
        end else begin
            for (int p = 0; p < 2; p++)
                if (com[p] && hold_prev[1 - p] && sf[p] == m_func[1 - p]) rej[p] = 1'b1;
        end
`endif
        for (int p = 0; p < 2; p++) begin
            if (com[p] && !rej[p]) begin
                m_user[p] = su[p];
                m_func[p] = sf[p];
                m_vend[p] = c + HOLD - 1;
            end
        end
        if (evb[1]) m_sel[0] = (m_sel[0] + 1) % 4;
        if (evb[2]) m_sel[1] = (m_sel[1] + 1) % 4;
        rec.cyc = c;
        rec.v0  = (c <= m_vend[0]) ? 1 : 0;
        rec.v1  = (c <= m_vend[1]) ? 1 : 0;
        rec.u0  = m_user[0];
        rec.u1  = m_user[1];
        rec.f0  = m_func[0];
        rec.f1  = m_func[1];
        rec.s0  = m_sel[0];
        rec.s1  = m_sel[1];
        rec.er  = (rej[0] || rej[1]) ? 1 : 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   len, endp, body, k, exp_f0;
        logic [7:0] ch_r;
        exp_t rec;
        logic got, seen;

        rst_n = 1'b0;
        ch    = 8'hA5;
        btn   = 4'hF;
        for (int p = 0; p < 2; p++) begin
            m_vend[p] = -100;
            m_user[p] = 0;
            m_func[p] = 0;
            m_sel[p]  = 0;
        end

        // Asynchronous reset: outputs clear before any clock edge.
        #2;
        chk("rst_valid0", 8'(valid0), 8'd0);
        chk("rst_valid1", 8'(valid1), 8'd0);
        chk("rst_user0",  8'(user0),  8'd0);
        chk("rst_user1",  8'(user1),  8'd0);
        chk("rst_func0",  8'(func0),  8'd0);
        chk("rst_func1",  8'(func1),  8'd0);
        chk("rst_sel0",   8'(sel0),   8'd0);
        chk("rst_sel1",   8'(sel1),   8'd0);
        chk("rst_err",    8'(err),    8'd0);

        ch  = 8'h00;
        btn = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int r = 0; r < ROUNDS; r++) begin
            for (int i = 0; i < MAXLEN; i++) begin
                pat[i] = 4'h0;
                ev[i]  = 4'h0;
            end
            len = 0;
            if (r == 0) begin
                // Clean 10-cycle press of commit 0 with CH=0000_0101.
                ch_r = 8'b0000_0101;
                for (int i = 5; i < 15; i++) pat[i][0] = 1'b1;
                ev[5 + LAT][0] = 1'b1;
                len = 15;
            end else begin
                ch_r = 8'($urandom);
                body = $urandom_range(30, 70);
                for (int b = 0; b < 4; b++) begin
                    gen_button(b, body, endp);
                    if (endp > len) len = endp;
                end
                if (r % 4 == 0) begin
                    // Simultaneous commits on both ports.
                    for (int i = 0; i < MAXLEN; i++) begin
                        pat[i][3] = pat[i][0];
                        ev[i][3]  = ev[i][0];
                    end
                    ch_r[7] = ch_r[3];
                end
            end
            len += TAIL;

            k = cyc;
            for (int i = 0; i < len; i++) begin
                model_cycle(k + i, ev[i], ch_r, rec);
                sb_q.push_back(rec);
            end

            ch  = ch_r;
            btn = pat[0];
            for (int i = 1; i < len; i++) begin
                @(posedge clk);
                #1;
                btn = pat[i];
            end
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
        chk("scoreboard_drained", 8'(sb_q.size()), 8'd0);

        // Reset in the middle of a hold period.
        ch  = 8'h0F;
        btn = 4'b0010;
        repeat (8) @(posedge clk);
        #1 btn = 4'b0000;
        repeat (8) @(posedge clk);
        #1 btn = 4'b0001;
        m_sel[0] = (m_sel[0] + 1) % 4;
        exp_f0 = 4 + m_sel[0];
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = valid0;
        end
        chk("hold_valid0_rise", 8'(got), 8'd1);
        chk("hold_user0", 8'(user0), 8'b111);
        chk("hold_func0", 8'(func0), 8'(exp_f0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        btn = 4'b0000;
        #1;
        chk("midhold_rst_valid0", 8'(valid0), 8'd0);
        chk("midhold_rst_user0",  8'(user0),  8'd0);
        chk("midhold_rst_func0",  8'(func0),  8'd0);
        chk("midhold_rst_sel0",   8'(sel0),   8'd0);
        chk("midhold_rst_err",    8'(err),    8'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            seen = seen | valid0 | valid1;
        end
        chk("no_commit_after_reset", 8'(seen), 8'd0);
        chk("sel0_after_reset", 8'(sel0), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/captura_requisicao.md
CAPTURA_REQUISICAO -- requirements
Module: captura_requisicao

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles before a button level is accepted (range 1..255).
REQ-002 SHALL have parameter HOLD_CYCLES, default 8: cycles a committed request stays valid (range 1..255).
REQ-003 SHALL have port CLK, input, 1 bit: sole clock, rising edge.
REQ-004 SHALL have port RST_N, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port CH, input, 8 bits: raw slide switches, asynchronous to CLK.
REQ-006 SHALL have port BTN, input, 4 bits: raw buttons, active-high, asynchronous. Roles: BTN[0] commit port 0; BTN[1] step function port 0; BTN[2] step function port 1; BTN[3] commit port 1.
REQ-007 SHALL have ports USER0 and USER1, output, 3 bits each: latched user codes to the permission stage.
REQ-008 SHALL have ports FUNC0 and FUNC1, output, 3 bits each: latched function codes to the permission stage.
REQ-009 SHALL have ports VALID0 and VALID1, output, 1 bit each: the latched request is live.
REQ-010 SHALL have ports SEL0 and SEL1, output, 2 bits each: current function-step counters, shown on the display.
REQ-011 SHALL have port ERR, output, 1 bit: one-cycle pulse when a commit is rejected.

Function
REQ-012 SHALL synchronise CH and BTN through two flops each. CH SHALL NOT be debounced.
REQ-013 SHALL debounce each synchronised BTN bit:
- Debounced level changes only after DEBOUNCE_CYCLES consecutive cycles at the new level.
- Any bounce restarts the count.
- A rising edge of the debounced level produces exactly one 1-cycle pulse.
REQ-014 SHALL assert VALIDn exactly 2+DEBOUNCE_CYCLES+1 rising edges after the first edge that samples a clean press of the commit button.
REQ-015 SHALL increment SELn modulo 4 on each BTN[1]/BTN[2] pulse (3 wraps to 0).
REQ-016 SHALL snapshot values on a port-0 commit pulse: USER0={CH[0],CH[1],CH[2]}, FUNC0={CH[3],SEL0}.
REQ-017 SHALL snapshot values on a port-1 commit pulse: USER1={CH[4],CH[5],CH[6]}, FUNC1={CH[7],SEL1}.
REQ-018 SHALL run one FSM per port, states IDLE and HOLD:
- IDLE to HOLD on an accepted commit, loading the timer with HOLD_CYCLES.
- HOLD decrements the timer each cycle.
- HOLD to IDLE when the timer reaches 0; VALIDn is high for exactly HOLD_CYCLES cycles.
REQ-019 SHALL, on a commit in HOLD, re-snapshot the outputs and reload the timer; VALIDn stays high without a gap.
REQ-020 SHALL use the pre-increment SELn when a step pulse and a commit pulse occur in the same cycle.
REQ-021 SHALL keep USERn/FUNCn at their last snapshot while VALIDn is low.
REQ-022 SHALL process both ports independently; simultaneous commits are both accepted, except as stated in REQ-026.

Reset
REQ-023 SHALL, while RST_N=0, asynchronously clear all outputs to 0, both FSMs to IDLE, all timers, debounce counters and synchroniser flops.
REQ-024 SHALL, on reset mid-HOLD, drop VALIDn immediately; no commit is pending after release.

Configuration
REQ-025 SHALL support macro CAPTURA_LOCK_EN.
REQ-026 SHALL, with CAPTURA_LOCK_EN defined:
- Reject a commit whose snapshot FUNC equals the other port's FUNC while that port is in HOLD.
- On rejection, leave the committing port's state unchanged and pulse ERR.
- On simultaneous commits with equal FUNC, accept the port with the higher USER code (tie: port 0) and reject the other, with one ERR pulse.
REQ-027 SHALL, without CAPTURA_LOCK_EN, accept all commits; ERR is tied 0.

Structure
REQ-028 SHALL place the following in shared package captura_pkg:
- port-state enum (IDLE, HOLD);
- USER_W=3, FUNC_W=3, SEL_W=2;
- commit/step bit-index constants for BTN.
REQ-029 SHALL implement the synchroniser plus debouncer as sub-module debounce_botao, instantiated four times.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8)
REQ-030 Clean press: CH=8'b0000_0101, BTN[0] held 10 cycles -> VALID0 high 7 edges after press, for 8 cycles; USER0=3'b101, FUNC0=3'b000.
REQ-031 Bounce and wrap: BTN[1] toggles every 2 cycles for 12 cycles, then pressed clean 5 times -> SEL0 steps only on clean presses: 0,1,2,3,0,1.
REQ-032 Re-commit: second BTN[0] press at HOLD cycle 5 with CH[3]=1 -> VALID0 has no gap, FUNC0=3'b1xx, 8 further valid cycles.
REQ-033 Reset mid-HOLD: RST_N low at HOLD cycle 3 -> VALID0, USER0, FUNC0 and SEL0 are 0 in the same cycle.
REQ-034 Lock, macro defined: port 1 in HOLD with FUNC1=3'b001, port 0 commits FUNC0=3'b001 -> ERR pulses once, VALID0 stays 0. Macro undefined -> both ports valid, ERR=0.
REQ-035 Simultaneous commits, macro defined: USER0=3'b010, USER1=3'b110, equal FUNC -> only VALID1 rises, one ERR pulse.
